// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-to-1 stream mux with fixed/round-robin grant and one-entry output register
// Round-robin mode and its pointer are compiled in only when STREAM_MUX_RR_EN is defined.
module stream_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_chan
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;

    logic             accept;
    logic             fix_gnt;
    logic [SEL_W-1:0] fix_idx;
    logic             gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;

    // An out-of-range sel never matches any index, so nothing is granted.
    always_comb begin
        fix_gnt = 1'b0;
        fix_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                fix_gnt = 1'b1;
                fix_idx = SEL_W'(i);
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic             hi_gnt;
    logic             lo_gnt;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;

    // Lowest valid index at/above ptr wins; otherwise wrap to the lowest valid below ptr.
    always_comb begin
        hi_gnt = 1'b0;
        lo_gnt = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (SEL_W'(i) >= ptr_q) begin
                    hi_gnt = 1'b1;
                    hi_idx = SEL_W'(i);
                end else begin
                    lo_gnt = 1'b1;
                    lo_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        if (mode) begin
            gnt     = hi_gnt || lo_gnt;
            gnt_idx = hi_gnt ? hi_idx : lo_idx;
        end else begin
            gnt     = fix_gnt;
            gnt_idx = fix_idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && mode) begin
            ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign gnt         = fix_gnt;
    assign gnt_idx     = fix_idx;
`endif

    assign accept = (state_q == EMPTY) || out_ready;
    assign xfer   = gnt && accept && !reset;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                in_ready[i] = xfer;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
        end else if (xfer) begin
            state_q <= FULL;
            data_q  <= gnt_data;
            chan_q  <= gnt_idx;
        end else if (out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;
endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - scoreboard bench for stream_mux (4-channel and 3-channel instances)
module tb_stream_mux;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [W-1:0]   ch [4];
    logic [4*W-1:0] in_data;
    logic [3:0]     in_valid;
    logic [3:0]     in_ready;
    logic [1:0]     sel;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_chan;

    logic [W-1:0]   ch3 [3];
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic [1:0]     sel3;
    logic           mode3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic           out_ready3;
    logic [1:0]     out_chan3;

    assign in_data  = {ch[3], ch[2], ch[1], ch[0]};
    assign in_data3 = {ch3[2], ch3[1], ch3[0]};

    stream_mux #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    stream_mux #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_e;
    int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Every completed output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got chan %0d data %h, nothing expected", out_chan, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_out_data", 64'(out_data), 64'(mon_e[W-1:0]));
                check("sb_out_chan", 64'(out_chan), 64'(mon_e[W+1:W]));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) ch[i] = 32'hCAFE0000 + 32'(i);
        for (int i = 0; i < 3; i++) ch3[i] = 32'hBEEF0000 + 32'(i);
        sel3       = 2'd3;
        mode3      = 1'b0;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;

        // Reset held for two edges with all inputs valid
        step();
        step();
        at_neg();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_in_ready3", 64'(in_ready3), 64'h0);

        // Fixed mode, single transfer from channel 2
        step();
        reset    = 1'b0;
        sel      = 2'd2;
        out_ready = 1'b1;
        at_neg();
        check("fix_in_ready", 64'(in_ready), 64'b0100);
        check("oor_in_ready3", 64'(in_ready3), 64'h0);
        exp_q.push_back({2'd2, 32'hCAFE0002});
        step();
        in_valid = 4'b0000;
        at_neg();
        check("fix_out_valid", 64'(out_valid), 64'd1);
        check("oor_out_valid3", 64'(out_valid3), 64'd0);
        step();
        at_neg();
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_hold_data", 64'(out_data), 64'hCAFE0002);
        check("drain_hold_chan", 64'(out_chan), 64'd2);

        // Backpressure: three held cycles, then drain and refill together
        step();
        out_ready = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        at_neg();
        check("bp_first_ready", 64'(in_ready), 64'b0010);
        exp_q.push_back({2'd1, 32'hCAFE0001});
        step();
        ch[1] = 32'h11110001;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("bp_in_ready", 64'(in_ready), 64'h0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'hCAFE0001);
            check("bp_out_chan", 64'(out_chan), 64'd1);
            step();
            sel = (k == 0) ? 2'd0 : 2'd1;
        end
        out_ready = 1'b1;
        exp_q.push_back({2'd1, 32'h11110001});
        at_neg();
        check("bp_release_ready", 64'(in_ready), 64'b0010);
        step();
        in_valid = 4'b0000;
        at_neg();
        check("bp_no_bubble", 64'(out_valid), 64'd1);
        step();
        at_neg();
        check("bp_drained", 64'(out_valid), 64'd0);

`ifdef STREAM_MUX_RR_EN
        // Round-robin over channels 0,1,3
        step();
        ch[1]    = 32'hCAFE0001;
        mode     = 1'b1;
        in_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back({2'(rr_seq[k]), 32'hCAFE0000 + 32'(rr_seq[k])});
            at_neg();
            check("rr_in_ready", 64'(in_ready), 64'(4'b0001 << rr_seq[k]));
            step();
        end
        in_valid = 4'b0000;
        at_neg();
        step();
        at_neg();
        check("rr_drained", 64'(out_valid), 64'd0);
`endif

        // Reset while a held entry is blocked; the entry is discarded
        step();
        mode      = 1'b1;
        sel       = 2'd2;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        at_neg();
        check("mr_load_ready", 64'(in_ready), 64'b0100);
        step();
        in_valid = 4'b1111;
        at_neg();
        check("mr_full_valid", 64'(out_valid), 64'd1);
        check("mr_full_chan", 64'(out_chan), 64'd2);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        at_neg();
        check("mr_rst_in_ready", 64'(in_ready), 64'h0);
        step();
        reset = 1'b0;
        at_neg();
        check("mr_cleared_valid", 64'(out_valid), 64'd0);
`ifdef STREAM_MUX_RR_EN
        check("mr_rr_restart", 64'(in_ready), 64'b0001);
        exp_q.push_back({2'd0, 32'hCAFE0000});
`else
        check("mr_fix_after", 64'(in_ready), 64'b0100);
        exp_q.push_back({2'd2, 32'hCAFE0002});
`endif
        step();
        in_valid = 4'b0000;
        at_neg();
        step();
        at_neg();
        check("mr_drained", 64'(out_valid), 64'd0);

        // 3-channel instance: still idle on sel=3, then a legal select
        check("oor_idle_valid3", 64'(out_valid3), 64'd0);
        step();
        sel3 = 2'd1;
        at_neg();
        check("n3_in_ready", 64'(in_ready3), 64'b010);
        step();
        at_neg();
        check("n3_out_valid", 64'(out_valid3), 64'd1);
        check("n3_out_chan", 64'(out_chan3), 64'd1);
        check("n3_out_data", 64'(out_data3), 64'hBEEF0001);

        step();
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
